// File: rtl/wave_table_channel.sv
// Wave-table playback channel: byte-packed sample RAM with CPU access, period timer,
// step counter, sample latch, volume shifter and length counter.
module wave_table_channel #(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  parameter int PERIOD_W = 11,
  parameter int LEN_W    = 8,
  localparam int SPB     = 8 / SAMPLE_W,
  localparam int BYTES   = DEPTH / SPB,
  localparam int ADDR_W  = $clog2(BYTES),
  localparam int STEP_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slow_clk_en,
  input  logic                cpu_en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [7:0]          rdata,
  input  logic [7:0]          wdata,
  input  logic                write,
  input  logic                dac_en,
  input  logic                init,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          volume,
  input  logic                length_load,
  input  logic [LEN_W-1:0]    length_data,
  input  logic                length_en,
  input  logic                length_tick,
  output logic                playing,
  output logic [STEP_W-1:0]   step,
  output logic [SAMPLE_W-1:0] wave
);

  localparam int SPB_W = $clog2(SPB);

  logic [7:0]          mem [BYTES];
  logic [PERIOD_W-1:0] timer;
  logic [SAMPLE_W-1:0] sample_buf;
  logic [LEN_W-1:0]    len_cnt;

  logic [ADDR_W-1:0]   eff;
  logic [STEP_W-1:0]   step_nxt;
  logic [7:0]          nxt_byte;
  logic [SAMPLE_W-1:0] next_sample;
  logic                start;
  logic                len_tick;
  logic                len_expire;
  int unsigned         lane;

  // While playing the CPU is locked onto the byte currently being played.
  always_comb begin
    eff         = playing ? ADDR_W'(step >> SPB_W) : addr;
    rdata       = mem[eff];
    step_nxt    = step + 1'b1;
    nxt_byte    = mem[ADDR_W'(step_nxt >> SPB_W)];
    lane        = 32'(step_nxt) % SPB;
    // Even sample sits in the high nibble, so lane 0 needs the largest shift.
    next_sample = SAMPLE_W'(nxt_byte >> ((SPB - 1 - lane) * SAMPLE_W));
    start       = init && dac_en;
    len_tick    = length_tick && length_en && (len_cnt != '1);
    len_expire  = len_tick && (LEN_W'(len_cnt + 1'b1) == '1);
    wave        = (volume == 2'd0) ? '0 : SAMPLE_W'(sample_buf >> (volume - 2'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BYTES; i++) mem[i] <= '0;
      timer      <= '0;
      step       <= '0;
      sample_buf <= '0;
      len_cnt    <= '0;
      playing    <= 1'b0;
    end else begin
      if (cpu_en && write) mem[eff] <= wdata;

      if (start) begin
        playing <= 1'b1;
        timer   <= period;
        step    <= '0;
      end else if (!dac_en) begin
        playing <= 1'b0;
      end else if (len_expire) begin
        playing <= 1'b0;
      end else if (slow_clk_en && playing) begin
        if (timer == '1) begin
          timer      <= period;
          step       <= step_nxt;
          sample_buf <= next_sample;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      if (length_load)               len_cnt <= length_data;
      else if (start && len_cnt == '1) len_cnt <= '0;
      else if (len_tick)             len_cnt <= len_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wave_table_channel.sv
// Bench for wave_table_channel: 4-bit/32 and 8-bit/64 instances on shared stimulus,
// checked each cycle against a sample-level model, plus directed literal checks.
module tb_wave_table_channel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, slow_clk_en, cpu_en, write, dac_en, init;
  logic        length_load, length_en, length_tick;
  logic [5:0]  addr;
  logic [7:0]  wdata, length_data;
  logic [10:0] period;
  logic [1:0]  volume;

  logic [7:0] r4, r8;
  logic       p4, p8;
  logic [4:0] st4;
  logic [5:0] st8;
  logic [3:0] w4;
  logic [7:0] w8;

  wave_table_channel #(.SAMPLE_W(4), .DEPTH(32), .PERIOD_W(11), .LEN_W(8)) u4 (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en), .addr(addr[3:0]),
    .rdata(r4), .wdata(wdata), .write(write), .dac_en(dac_en), .init(init), .period(period),
    .volume(volume), .length_load(length_load), .length_data(length_data), .length_en(length_en),
    .length_tick(length_tick), .playing(p4), .step(st4), .wave(w4));

  wave_table_channel #(.SAMPLE_W(8), .DEPTH(64), .PERIOD_W(11), .LEN_W(8)) u8 (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en), .addr(addr),
    .rdata(r8), .wdata(wdata), .write(write), .dac_en(dac_en), .init(init), .period(period),
    .volume(volume), .length_load(length_load), .length_data(length_data), .length_en(length_en),
    .length_tick(length_tick), .playing(p8), .step(st8), .wave(w8));

  int total = 0;
  int bad   = 0;

  // Model: plain sample arrays per configuration (0: 4-bit x32, 1: 8-bit x64).
  int SW [2] = '{4, 8};
  int DP [2] = '{32, 64};
  int ms [2][64];
  int mplay [2], mstep [2], mtimer [2], mbuf [2], mlen [2];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rbyte(int c, int n);
    if (SW[c] == 4) return ms[c][2*n] * 16 + ms[c][2*n+1];
    return ms[c][n];
  endfunction

  function automatic int eff(int c);
    int spb = 8 / SW[c];
    if (mplay[c] != 0) return mstep[c] / spb;
    return int'(addr) % (DP[c] / spb);
  endfunction

  function automatic int exp_wave(int c);
    if (volume == 0) return 0;
    return mbuf[c] >> (int'(volume) - 1);
  endfunction

  task automatic model_clock(int c);
    int e, nxt, nsamp;
    bit start, tk, expire;
    if (reset) begin
      for (int i = 0; i < 64; i++) ms[c][i] = 0;
      mplay[c] = 0; mstep[c] = 0; mtimer[c] = 0; mbuf[c] = 0; mlen[c] = 0;
      return;
    end
    e     = eff(c);
    nxt   = (mstep[c] + 1) % DP[c];
    nsamp = ms[c][nxt];
    if (cpu_en && write) begin
      if (SW[c] == 4) begin
        ms[c][2*e]   = int'(wdata) >> 4;
        ms[c][2*e+1] = int'(wdata) & 15;
      end else begin
        ms[c][e] = int'(wdata);
      end
    end
    start  = init && dac_en;
    tk     = length_tick && length_en && mlen[c] != 255;
    expire = tk && mlen[c] == 254;
    if (start) begin
      mplay[c] = 1; mtimer[c] = int'(period); mstep[c] = 0;
    end else if (!dac_en || expire) begin
      mplay[c] = 0;
    end else if (slow_clk_en && mplay[c] != 0) begin
      if (mtimer[c] == 2047) begin
        mtimer[c] = int'(period); mstep[c] = nxt; mbuf[c] = nsamp;
      end else begin
        mtimer[c]++;
      end
    end
    if (length_load)                 mlen[c] = int'(length_data);
    else if (start && mlen[c] == 255) mlen[c] = 0;
    else if (tk)                     mlen[c]++;
  endtask

  // Check settled outputs with current inputs, advance the model, cross one clock edge.
  task automatic cyc();
    #1;
    check("rdata4", 32'(r4), rbyte(0, eff(0)));
    check("play4",  32'(p4), mplay[0]);
    check("step4",  32'(st4), mstep[0]);
    check("wave4",  32'(w4), exp_wave(0));
    check("rdata8", 32'(r8), rbyte(1, eff(1)));
    check("play8",  32'(p8), mplay[1]);
    check("step8",  32'(st8), mstep[1]);
    check("wave8",  32'(w8), exp_wave(1));
    model_clock(0);
    model_clock(1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int vexp [4] = '{0, 12, 6, 3};
    reset = 1; slow_clk_en = 0; cpu_en = 0; write = 0; dac_en = 1; init = 0;
    length_load = 0; length_en = 0; length_tick = 0; addr = '0; wdata = '0;
    length_data = '0; period = '0; volume = '0;
    for (int c = 0; c < 2; c++) begin
      mplay[c] = 0; mstep[c] = 0; mtimer[c] = 0; mbuf[c] = 0; mlen[c] = 0;
      for (int i = 0; i < 64; i++) ms[c][i] = 0;
    end
    @(negedge clk); #1;
    model_clock(0); model_clock(1);
    @(negedge clk); #1;
    cyc();
    reset = 0;
    check("rst_play", 32'(p4), 0);
    check("rst_wave", 32'(w4), 0);
    check("rst_rdata", 32'(r4), 0);

    // RAM write / read-back while idle.
    cpu_en = 1; write = 1;
    for (int i = 0; i < 16; i++) begin
      addr = 6'(i); wdata = {4'(2 * (i % 8)), 4'(2 * (i % 8) + 1)}; cyc();
    end
    write = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = {4'(2 * (i % 8)), 4'(2 * (i % 8) + 1)};
      addr = 6'(i); cyc();
      check("readback", 32'(r4), int'(b));
    end

    // Playback cadence with period 2046.
    period = 11'd2046; volume = 2'd1; init = 1; cyc(); init = 0;
    check("init_play", 32'(p4), 1);
    check("init_step", 32'(st4), 0);
    slow_clk_en = 1; cyc(); cyc();
    check("first_step", 32'(st4), 1);
    check("first_wave", 32'(w4), 1);
    repeat (62) cyc();
    check("wrap_step", 32'(st4), 0);

    // Locked CPU access at step 9.
    repeat (18) cyc();
    slow_clk_en = 0; addr = '0; cyc();
    check("lock_step", 32'(st4), 9);
    check("lock_read", 32'(r4), 8'h89);
    write = 1; wdata = 8'hAA; cyc(); write = 0;
    dac_en = 0; cyc(); dac_en = 1; cyc();
    check("stop_play", 32'(p4), 0);
    addr = 6'd4; cyc();
    check("lock_wr_b4", 32'(r4), 8'hAA);
    addr = 6'd0; cyc();
    check("lock_wr_b0", 32'(r4), 8'h01);

    // Volume shifts on sample 0xC, then DAC off.
    init = 1; cyc(); init = 0;
    slow_clk_en = 1; repeat (24) cyc(); slow_clk_en = 0;
    check("vol_step", 32'(st4), 12);
    for (int v = 0; v < 4; v++) begin
      volume = 2'(v); cyc();
      check("vol_wave", 32'(w4), vexp[v]);
    end
    volume = 2'd1;
    dac_en = 0; cyc(); dac_en = 1;
    check("dac_off", 32'(p4), 0);

    // Length expiry.
    length_load = 1; length_data = 8'hFD; length_en = 1; init = 1; cyc();
    length_load = 0; init = 0;
    check("len_play0", 32'(p4), 1);
    length_tick = 1; cyc();
    check("len_play1", 32'(p4), 1);
    cyc(); length_tick = 0;
    check("len_play2", 32'(p4), 0);
    check("len_sat", mlen[0], 255);
    length_en = 0; cyc();

    // 8-bit instance: last sample and init colliding with overflow.
    addr = 6'h3F; wdata = 8'h80; write = 1; cyc(); write = 0;
    init = 1; cyc(); init = 0;
    slow_clk_en = 1; repeat (126) cyc(); slow_clk_en = 0;
    check("s8_step", 32'(st8), 63);
    check("s8_wave", 32'(w8), 8'h80);
    slow_clk_en = 1; cyc();
    init = 1; cyc(); init = 0; slow_clk_en = 0;
    check("s8_init_ovf", 32'(st8), 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      init        = ($urandom_range(0, 59) == 0);
      dac_en      = ($urandom_range(0, 39) != 0);
      slow_clk_en = $urandom_range(0, 1) == 1;
      period      = 11'($urandom_range(2040, 2047));
      cpu_en      = ($urandom_range(0, 3) != 0);
      write       = ($urandom_range(0, 7) == 0);
      addr        = 6'($urandom);
      wdata       = 8'($urandom);
      volume      = 2'($urandom);
      length_load = ($urandom_range(0, 49) == 0);
      length_data = 8'($urandom_range(240, 255));
      length_en   = $urandom_range(0, 1) == 1;
      length_tick = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
